// File: rtl/softmax_stream.sv
// softmax_stream: buffered safe-softmax over a row of NUM-lane beats.
// Rows are loaded, max-subtracted/exponentiated/summed in place, then normalised per chunk on output.
module softmax_stream #(
  parameter int unsigned D_W    = 16,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned NUM    = 16,
  parameter int unsigned CHUNKS = 4,
  parameter int unsigned E_W    = 16,
  parameter int unsigned OUT_W  = 8
) (
  input  logic                 I_CLK,
  input  logic                 I_RST_N,
  input  logic                 I_VLD,
  output logic                 O_RDY,
  input  logic [NUM*D_W-1:0]   I_DATA,
  input  logic                 I_LAST,
  input  logic [NUM-1:0]       I_KEEP,
  output logic                 O_VLD,
  input  logic                 I_RDY,
  output logic [NUM*OUT_W-1:0] O_DATA,
  output logic                 O_LAST,
  output logic [NUM-1:0]       O_KEEP
);
  localparam int unsigned BUF_W = (D_W > E_W) ? D_W : E_W;
  localparam int unsigned SUM_W = E_W + $clog2(NUM*CHUNKS);
  localparam int unsigned CNT_W = $clog2(CHUNKS+1);
  localparam int unsigned PTR_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int unsigned DIF_W = D_W + 1;
  localparam int unsigned NUM_W = E_W + OUT_W;
  localparam int unsigned QW    = (NUM_W > SUM_W) ? NUM_W : SUM_W;
  localparam int          THR_I = -16 * (1 << FRAC);
  localparam logic signed [D_W-1:0] MOST_NEG = {1'b1, {(D_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXP, S_OUT} state_t;

  state_t                 state_q, state_d;
  logic [NUM*BUF_W-1:0]   buf_q [CHUNKS];
  logic signed [D_W-1:0]  max_q, max_d;
  logic [SUM_W-1:0]       sum_q, sum_d;
  logic [CNT_W-1:0]       ptr_q, ptr_d, n_q, n_d;
  logic [NUM-1:0]         keep_q, keep_d;
  logic                   rdy_q, rdy_d, vld_q, vld_d, last_q, last_d;
  logic [NUM*OUT_W-1:0]   data_q, data_d;
  logic [NUM-1:0]         okeep_q, okeep_d;

  logic                   buf_we_c;
  logic [NUM*BUF_W-1:0]   buf_wd_c;
  logic                   in_fire_c, in_last_c;
  logic [NUM-1:0]         in_keep_c;
  logic signed [D_W-1:0]  in_max_c;
  logic [NUM*BUF_W-1:0]   in_row_c, cur_row_c, exp_row_c;
  logic [SUM_W-1:0]       exp_sum_c;
  logic [NUM*OUT_W-1:0]   q_row_c;

  // e = 2^(E_W-1) * 2^(-|d|*log2e): 16-entry 2^(-k/16) table plus a right shift
  function automatic logic [E_W-1:0] exp_unit(input logic signed [DIF_W-1:0] d);
    logic signed [63:0] ds;
    logic [63:0] mag, y, ip, e;
    logic [3:0]  k;
    logic [16:0] lut;
    ds  = 64'(d);
    mag = 64'(-ds);
    y   = (mag * 64'd94548) >> 16;
    ip  = y >> FRAC;
    k   = 4'(y >> (FRAC - 4));
    case (k)
      4'd1:    lut = 17'd62757;
      4'd2:    lut = 17'd60097;
      4'd3:    lut = 17'd57549;
      4'd4:    lut = 17'd55109;
      4'd5:    lut = 17'd52773;
      4'd6:    lut = 17'd50535;
      4'd7:    lut = 17'd48393;
      4'd8:    lut = 17'd46341;
      4'd9:    lut = 17'd44376;
      4'd10:   lut = 17'd42495;
      4'd11:   lut = 17'd40694;
      4'd12:   lut = 17'd38968;
      4'd13:   lut = 17'd37316;
      4'd14:   lut = 17'd35734;
      4'd15:   lut = 17'd34219;
      default: lut = 17'd65536;
    endcase
    if (ip >= 64'(E_W)) begin
      e = '0;
    end else begin
      e = ((64'(lut) << (E_W-1)) >> 16) >> ip;
    end
    return E_W'(e);
  endfunction

  // Input beat: effective keep, running max over kept lanes, buffer image
  always_comb begin
    in_fire_c = I_VLD && rdy_q;
    in_last_c = I_LAST || (ptr_q == CNT_W'(CHUNKS-1));
    in_keep_c = I_LAST ? I_KEEP : '1;
    in_max_c  = max_q;
    in_row_c  = '0;
    for (int i = 0; i < NUM; i++) begin
      in_row_c[i*BUF_W +: BUF_W] = BUF_W'(signed'(I_DATA[i*D_W +: D_W]));
      if (in_keep_c[i] && (signed'(I_DATA[i*D_W +: D_W]) > in_max_c)) begin
        in_max_c = signed'(I_DATA[i*D_W +: D_W]);
      end
    end
  end

  assign cur_row_c = buf_q[PTR_W'(ptr_q)];

  // Exp stage for the chunk at ptr_q
  always_comb begin
    logic signed [D_W-1:0]   x;
    logic signed [DIF_W-1:0] d;
    logic [E_W-1:0]          e;
    logic                    masked;
    exp_row_c = '0;
    exp_sum_c = '0;
    for (int i = 0; i < NUM; i++) begin
      x      = signed'(cur_row_c[i*BUF_W +: D_W]);
      d      = DIF_W'(x) - DIF_W'(max_q);
      masked = (ptr_q == n_q - CNT_W'(1)) && !keep_q[i];
      e      = (masked || (d < DIF_W'(THR_I))) ? '0 : exp_unit(d);
      exp_row_c[i*BUF_W +: BUF_W] = BUF_W'(e);
      exp_sum_c = exp_sum_c + SUM_W'(e);
    end
  end

  // Normalising divider, one per lane, shared across chunks
  always_comb begin
    logic [QW-1:0] num, quo;
    q_row_c = '0;
    for (int i = 0; i < NUM; i++) begin
      num = QW'(cur_row_c[i*BUF_W +: E_W]) << OUT_W;
      if (sum_q == '0) begin
        quo = '0;
      end else begin
        quo = num / QW'(sum_q);
      end
      if (quo > QW'((1 << OUT_W) - 1)) begin
        quo = QW'((1 << OUT_W) - 1);
      end
      q_row_c[i*OUT_W +: OUT_W] = OUT_W'(quo);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    sum_d    = sum_q;
    ptr_d    = ptr_q;
    n_d      = n_q;
    keep_d   = keep_q;
    vld_d    = vld_q;
    last_d   = last_q;
    data_d   = data_q;
    okeep_d  = okeep_q;
    buf_we_c = 1'b0;
    buf_wd_c = exp_row_c;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (in_fire_c) begin
          buf_we_c = 1'b1;
          buf_wd_c = in_row_c;
          max_d    = in_max_c;
          if (in_last_c) begin
            n_d     = ptr_q + CNT_W'(1);
            ptr_d   = '0;
            keep_d  = in_keep_c;
            state_d = S_EXP;
          end else begin
            ptr_d   = ptr_q + CNT_W'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_EXP: begin
        buf_we_c = 1'b1;
        sum_d    = sum_q + exp_sum_c;
        if (ptr_q == n_q - CNT_W'(1)) begin
          ptr_d   = '0;
          state_d = S_OUT;
        end else begin
          ptr_d = ptr_q + CNT_W'(1);
        end
      end
      S_OUT: begin
        if (vld_q && I_RDY && last_q) begin
          state_d = S_IDLE;
          vld_d   = 1'b0;
          last_d  = 1'b0;
          ptr_d   = '0;
          n_d     = '0;
          sum_d   = '0;
          max_d   = MOST_NEG;
          keep_d  = '0;
        end else if ((!vld_q || I_RDY) && (ptr_q != n_q)) begin
          vld_d   = 1'b1;
          data_d  = q_row_c;
          last_d  = (ptr_q == n_q - CNT_W'(1));
          okeep_d = (ptr_q == n_q - CNT_W'(1)) ? keep_q : '1;
          ptr_d   = ptr_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_IDLE) || (state_d == S_LOAD);
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= S_IDLE;
      max_q   <= MOST_NEG;
      sum_q   <= '0;
      ptr_q   <= '0;
      n_q     <= '0;
      keep_q  <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      okeep_q <= '0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      ptr_q   <= ptr_d;
      n_q     <= n_d;
      keep_q  <= keep_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      data_q  <= data_d;
      okeep_q <= okeep_d;
    end
  end

  // Row buffer: scores on load, overwritten by exp values
  always_ff @(posedge I_CLK) begin
    if (buf_we_c) begin
      buf_q[PTR_W'(ptr_q)] <= buf_wd_c;
    end
  end

  assign O_RDY  = rdy_q;
  assign O_VLD  = vld_q;
  assign O_DATA = data_q;
  assign O_LAST = last_q;
  assign O_KEEP = okeep_q;

endmodule

// File: tb/tb_softmax_stream.sv
// tb_softmax_stream: directed vectors for softmax_stream with hand-computed probabilities.
module tb_softmax_stream;
  localparam int unsigned D_W = 16, FRAC = 8, NUM = 16, CHUNKS = 4, E_W = 16, OUT_W = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_vld, o_rdy, i_last, o_vld, i_rdy, o_last;
  logic [NUM*D_W-1:0]   i_data;
  logic [NUM-1:0]       i_keep, o_keep;
  logic [NUM*OUT_W-1:0] o_data;

  int total = 0;
  int bad   = 0;

  softmax_stream #(.D_W(D_W), .FRAC(FRAC), .NUM(NUM), .CHUNKS(CHUNKS), .E_W(E_W), .OUT_W(OUT_W)) dut (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VLD(i_vld), .O_RDY(o_rdy), .I_DATA(i_data),
    .I_LAST(i_last), .I_KEEP(i_keep), .O_VLD(o_vld), .I_RDY(i_rdy), .O_DATA(o_data),
    .O_LAST(o_last), .O_KEEP(o_keep)
  );

  always #5 clk = ~clk;

  typedef struct {
    string                name;
    logic [NUM*D_W-1:0]   din;
    logic [NUM-1:0]       keep;
    logic [NUM*OUT_W-1:0] dout;
    logic [NUM-1:0]       okeep;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [NUM*D_W-1:0] rep_in(input logic [D_W-1:0] v);
    logic [NUM*D_W-1:0] r;
    for (int i = 0; i < NUM; i++) r[i*D_W +: D_W] = v;
    return r;
  endfunction

  function automatic logic [NUM*OUT_W-1:0] rep_out(input logic [OUT_W-1:0] v);
    logic [NUM*OUT_W-1:0] r;
    for (int i = 0; i < NUM; i++) r[i*OUT_W +: OUT_W] = v;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [NUM*D_W-1:0] d, input logic l, input logic [NUM-1:0] k);
    int t = 0;
    i_vld = 1'b1; i_data = d; i_last = l; i_keep = k;
    while (!o_rdy && t < 50) begin tick(); t++; end
    chk("send_rdy", 128'(o_rdy), 128'(1));
    tick();
    i_vld = 1'b0; i_last = 1'b0;
  endtask

  task automatic recv(input string nm, input logic [NUM*OUT_W-1:0] d, input logic l, input logic [NUM-1:0] k);
    int t = 0;
    while (!o_vld && t < 50) begin tick(); t++; end
    chk({nm, "_vld"},  128'(o_vld),  128'(1));
    chk({nm, "_data"}, 128'(o_data), 128'(d));
    chk({nm, "_last"}, 128'(o_last), 128'(l));
    chk({nm, "_keep"}, 128'(o_keep), 128'(k));
    i_rdy = 1'b1;
    tick();
  endtask

  // Called just after the last input accept edge: O_VLD must stay low n+1 edges
  task automatic lat_check(input string nm, input int n);
    chk({nm, "_rdy_low"}, 128'(o_rdy), 128'(0));
    chk({nm, "_lat0"}, 128'(o_vld), 128'(0));
    for (int j = 1; j <= n; j++) begin
      tick();
      chk({nm, "_lat"}, 128'(o_vld), 128'(0));
    end
    tick();
  endtask

  task automatic end_check(input string nm);
    chk({nm, "_vld_end"}, 128'(o_vld), 128'(0));
    chk({nm, "_rdy_end"}, 128'(o_rdy), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NUM*D_W-1:0] d;
    rst_n = 1'b0; i_vld = 1'b0; i_data = '0; i_last = 1'b0; i_keep = '0; i_rdy = 1'b1;

    vecs[0] = '{"ones",     rep_in(16'h0100), 16'hFFFF, rep_out(8'h10), 16'hFFFF};
    vecs[1] = '{"sat",      rep_in(16'hF000), 16'hFFFF, '0,             16'hFFFF};
    vecs[1].din[3*D_W +: D_W]     = 16'h1000;
    vecs[1].dout[3*OUT_W +: OUT_W] = 8'hFF;
    vecs[2] = '{"keep000f", rep_in(16'h0200), 16'h000F, {96'h0, 32'h40404040}, 16'h000F};
    vecs[3] = '{"keep0000", rep_in(16'h0200), 16'h0000, '0,             16'h0000};
    vecs[4] = '{"two_hot",  rep_in(16'hF000), 16'hFFFF, '0,             16'hFFFF};
    vecs[4].din[0*D_W +: D_W]      = 16'h0000;
    vecs[4].din[5*D_W +: D_W]      = 16'h0000;
    vecs[4].dout[0*OUT_W +: OUT_W] = 8'h80;
    vecs[4].dout[5*OUT_W +: OUT_W] = 8'h80;
    vecs[5] = '{"maxpos",   rep_in(16'h7FFF), 16'hFFFF, rep_out(8'h10), 16'hFFFF};
    vecs[6] = '{"maxneg",   rep_in(16'h8000), 16'hFFFF, rep_out(8'h10), 16'hFFFF};
    vecs[7] = '{"maskmax",  rep_in(16'h7FFF), 16'h0002, '0,             16'h0002};
    vecs[7].din[1*D_W +: D_W]      = 16'h0000;
    vecs[7].dout[1*OUT_W +: OUT_W] = 8'hFF;

    // Reset values and O_RDY rising one edge after release
    #12;
    chk("rst_rdy", 128'(o_rdy), 128'(0));
    chk("rst_vld", 128'(o_vld), 128'(0));
    chk("rst_data", 128'(o_data), 128'(0));
    chk("rst_last", 128'(o_last), 128'(0));
    chk("rst_keep", 128'(o_keep), 128'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_rdy_pre", 128'(o_rdy), 128'(0));
    tick();
    chk("rst_rdy_post", 128'(o_rdy), 128'(1));

    // Single-beat rows from the table
    for (int v = 0; v < 8; v++) begin
      send_beat(vecs[v].din, 1'b1, vecs[v].keep);
      lat_check(vecs[v].name, 1);
      recv(vecs[v].name, vecs[v].dout, 1'b1, vecs[v].okeep);
      end_check(vecs[v].name);
    end

    // Full row, I_LAST on the 4th beat
    for (int b = 0; b < 4; b++) send_beat(rep_in(16'h0300), (b == 3), 16'hFFFF);
    lat_check("full4", 4);
    for (int b = 0; b < 4; b++) recv("full4", rep_out(8'h04), (b == 3), 16'hFFFF);
    end_check("full4");

    // Three-beat row with distinct chunks: order must be preserved
    send_beat(rep_in(16'h0000), 1'b0, 16'hFFFF);
    send_beat(rep_in(16'hF000), 1'b0, 16'hFFFF);
    send_beat(rep_in(16'hF000), 1'b1, 16'h0000);
    lat_check("ord3", 3);
    recv("ord3_b0", rep_out(8'h10), 1'b0, 16'hFFFF);
    recv("ord3_b1", '0, 1'b0, 16'hFFFF);
    recv("ord3_b2", '0, 1'b1, 16'h0000);
    end_check("ord3");

    // Forced last on the 4th beat, 5-cycle stall mid-output
    for (int b = 0; b < 4; b++) send_beat(rep_in(16'h0500), 1'b0, 16'h0000);
    lat_check("forced", 4);
    recv("forced_b0", rep_out(8'h04), 1'b0, 16'hFFFF);
    recv("forced_b1", rep_out(8'h04), 1'b0, 16'hFFFF);
    i_rdy = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("stall_vld", 128'(o_vld), 128'(1));
      chk("stall_data", 128'(o_data), 128'(rep_out(8'h04)));
      chk("stall_last", 128'(o_last), 128'(0));
      chk("stall_rdy", 128'(o_rdy), 128'(0));
    end
    recv("forced_b2", rep_out(8'h04), 1'b0, 16'hFFFF);
    recv("forced_b3", rep_out(8'h04), 1'b1, 16'hFFFF);
    end_check("forced");

    // Reset during S_EXP aborts the row
    for (int b = 0; b < 4; b++) send_beat(rep_in(16'h0100), 1'b0, 16'hFFFF);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rexp_vld", 128'(o_vld), 128'(0));
    chk("rexp_rdy", 128'(o_rdy), 128'(0));
    chk("rexp_data", 128'(o_data), 128'(0));
    chk("rexp_last", 128'(o_last), 128'(0));
    chk("rexp_keep", 128'(o_keep), 128'(0));
    #10;
    rst_n = 1'b1;
    for (int s = 0; s < 8; s++) begin
      tick();
      chk("rexp_quiet", 128'(o_vld), 128'(0));
    end
    send_beat(rep_in(16'h0100), 1'b1, 16'hFFFF);
    lat_check("rexp_after", 1);
    recv("rexp_after", rep_out(8'h10), 1'b1, 16'hFFFF);
    end_check("rexp_after");

    // Reset while an output beat is stalled
    send_beat(rep_in(16'h0100), 1'b1, 16'hFFFF);
    i_rdy = 1'b0;
    tick(); tick();
    chk("rout_pre_vld", 128'(o_vld), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("rout_vld", 128'(o_vld), 128'(0));
    chk("rout_data", 128'(o_data), 128'(0));
    chk("rout_last", 128'(o_last), 128'(0));
    chk("rout_keep", 128'(o_keep), 128'(0));
    #10;
    rst_n = 1'b1;
    i_rdy = 1'b1;
    for (int s = 0; s < 4; s++) begin
      tick();
      chk("rout_quiet", 128'(o_vld), 128'(0));
    end
    d = rep_in(16'h0100);
    send_beat(d, 1'b1, 16'hFFFF);
    lat_check("rout_after", 1);
    recv("rout_after", rep_out(8'h10), 1'b1, 16'hFFFF);
    end_check("rout_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/softmax_stream.md
# softmax_stream

Streaming, parametrised safe-softmax engine for the MHA attention path. Accepts a score row of up to NUM*CHUNKS elements as NUM-lane beats over a valid/ready handshake and buffers it. It subtracts the row maximum, exponentiates, sums and normalises, then returns the probabilities as NUM-lane beats with backpressure. Supports runtime row length via last-beat and lane-keep signalling, so partial rows and masked lanes are handled.

## Interface
- D_W, 16: input score width, signed two's complement.
- FRAC, 8: fractional bits of input scores.
- NUM, 16: lanes per beat.
- CHUNKS, 4: maximum beats per row; buffer depth.
- E_W, 16: exp value width, unsigned Q1.(E_W-1).
- OUT_W, 8: output probability width, unsigned Q0.OUT_W.
- I_CLK  in  1  clock.
- I_RST_N  in  1  reset, asynchronous, active-low.
- I_VLD  in  1  input beat valid.
- O_RDY  out  1  block can accept an input beat.
- I_DATA  in  NUM x D_W  scores; lane i of beat k is element k*NUM+i.
- I_LAST  in  1  final beat of row.
- I_KEEP  in  NUM  lane-valid mask; sampled on last beat only, all-ones implied otherwise.
- O_VLD  out  1  output beat valid.
- I_RDY  in  1  downstream accepts output beat.
- O_DATA  out  NUM x OUT_W  probabilities.
- O_LAST  out  1  final output beat of row.
- O_KEEP  out  NUM  echo of row keep mask on last beat; all-ones otherwise.

## Operation
- States: S_IDLE, S_LOAD, S_EXP, S_OUT.
- S_IDLE:
  - O_RDY=1; max register = most-negative D_W value; sum = 0; pointers = 0.
  - First accepted beat stores chunk 0, updates max, and goes to S_LOAD, or to S_EXP if last.
- S_LOAD:
  - O_RDY=1. Each I_VLD&&O_RDY beat is written to buffer[wr_ptr]; wr_ptr increments.
  - max = max(max, kept lanes).
  - A beat is last when I_LAST=1 or wr_ptr==CHUNKS-1, which forces last with keep all-ones. Latch n = beats, keep mask; go to S_EXP.
- S_EXP:
  - O_RDY=0. One chunk per cycle, chunk 0..n-1.
  - Per lane: d = x - max, computed at D_W+1 bits, always <= 0.
  - If d < -16.0 or the lane is masked, e = 0. Otherwise e = team exp unit(d).
  - The exp unit must return exactly 2^(E_W-1) for d=0.
  - e overwrites the buffer entry. sum += sum of NUM lanes; sum width E_W+clog2(NUM*CHUNKS), never overflows.
  - After chunk n-1, go to S_OUT.
- S_OUT:
  - Output register loads chunk rd_ptr with q = floor(e * 2^(OUT_W+1-E_W+E_W-1) / sum) = floor(e*2^OUT_W / 2^(E_W-1) / (sum/2^(E_W-1))), i.e. probability scaled by 2^OUT_W.
  - q saturates to 2^OUT_W-1. sum==0 gives q=0.
  - O_VLD held with O_DATA, O_LAST and O_KEEP stable until I_RDY.
  - On O_VLD&&I_RDY, the next chunk loads in the same edge; after the last beat, go to S_IDLE with O_VLD=0.
- Divider is combinational, NUM instances, shared across chunks.

## Timing
- Reset values: O_RDY=0 during reset, 1 after the first clock out of reset. O_VLD=0, O_DATA=0, O_LAST=0, O_KEEP=0, all state cleared.
- Input throughput 1 beat/cycle while O_RDY=1.
- Latency: with n beats, the last input is accepted at edge E0. S_EXP occupies edges E1..En. The first output beat registers at En+1, so O_VLD is high n+1 cycles after the last input accept.
- Output beats are 1/cycle when I_RDY=1. There is no bubble between beats.
- Next row accepted in the cycle after the final output handshake, via S_IDLE.
- Async reset at any state aborts the row immediately. No partial output follows.

## Test plan
- Single beat, all lanes 0x0100, I_LAST=1, I_KEEP=all-ones -> one output beat, all lanes 0x10, O_LAST=1. O_VLD rises 2 cycles after accept.
- 4 beats (CHUNKS=4) of all 0x0300, I_LAST only on the 4th -> 4 output beats, all lanes 0x04, O_LAST only on the 4th, order preserved.
- Single beat, lane 3 = 0x1000, others 0xF000 -> lane 3 = 0xFF (saturated), all others 0x00.
- Single last beat, all inputs equal, I_KEEP=0x000F -> lanes 0..3 = 0x40, lanes 4..15 = 0x00, O_KEEP=0x000F. I_KEEP=0x0000 -> all lanes 0x00.
- 4 beats with I_LAST never asserted, I_RDY low 5 cycles mid-output -> 4th beat forced last. Output stable while stalled, no beat lost or duplicated. O_RDY=0 until the final output handshake.
- Reset pulsed during S_EXP -> all outputs 0 immediately. The following single-beat row of all 0x0100 still yields 0x10 on every lane.
